mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory (registered read data, one-cycle latency, byte-masked writes) between the core's instruction-fetch port and its load/store port. Sits between `toplevel` and a unified memory. It grants at most one access per cycle, tracks which requester owns the in-flight response, and routes the read data back. A starvation guard keeps fetch alive under sustained data traffic.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, the load/store port and the unified memory port
// of mem_port_arbiter. The arbiter connects through the slave modport; the
// core/memory environment connects through the master modport.

interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    // Instruction-fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [MW-1:0] d_mask;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    // Unified single-port memory
    logic          m_req;
    logic          m_we;
    logic [MW-1:0] m_mask;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, i_flush,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_mask, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_mask, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr, i_flush,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_mask, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_mask, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory (one-cycle read latency,
// byte-masked writes) between the fetch port and the load/store port.
// At most one access is granted per cycle; data has priority over fetch.
// An owner register remembers which port the next-cycle memory response
// belongs to and routes it back. Each port holds its last delivered data.
//
// Optional feature: define MEM_PORT_ARBITER_STARVE_GUARD_EN to build the
// starvation counter that forces a fetch grant after STARVE_LIMIT
// consecutive data grants while fetch is waiting. Without it, priority is
// strictly data over fetch.

module mem_port_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_DR   = 2'd2,
        OWN_DW   = 2'd3
    } owner_e;

    owner_e        owner_r;
    owner_e        owner_nxt_s;
    logic          i_drop_r;
    logic          i_drop_nxt_s;

    logic          i_gnt_s;
    logic          d_gnt_s;
    logic          guard_fire_s;

    logic          i_rvalid_s;
    logic          d_rvalid_s;
    logic [DW-1:0] i_rdata_s;
    logic [DW-1:0] d_rdata_s;
    logic [DW-1:0] i_hold_r;
    logic [DW-1:0] d_hold_r;

    logic          m_we_s;
    logic [MW-1:0] m_mask_s;
    logic [AW-1:0] m_addr_s;
    logic [DW-1:0] m_wdata_s;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;

    // Guard fires only when both ports compete and data has already won LIMIT times in a row.
    always_comb begin
        guard_fire_s = (starve_cnt_r == LIMIT_C) && bus.i_req && bus.d_req;
    end

    // Count consecutive data grants while fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 4'd0;
        end else if (i_gnt_s || !bus.i_req) begin
            starve_cnt_r <= 4'd0;
        end else if (d_gnt_s && (starve_cnt_r != 4'hF)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    logic [31:0] unused_limit_s;

    // Strict data-over-fetch priority: the guard never fires.
    always_comb begin
        guard_fire_s   = 1'b0;
        unused_limit_s = 32'(STARVE_LIMIT);
    end
`endif

    // Arbitration: data wins unless the guard forces fetch; nothing is granted during reset.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst) begin
            if (bus.d_req && !guard_fire_s) begin
                d_gnt_s = 1'b1;
            end else if (bus.i_req) begin
                i_gnt_s = 1'b1;
            end else begin
                i_gnt_s = 1'b0;
                d_gnt_s = 1'b0;
            end
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Memory command mux: the granted port drives the memory, idle cycles drive zeros.
    always_comb begin
        m_we_s    = 1'b0;
        m_mask_s  = {MW{1'b0}};
        m_addr_s  = {AW{1'b0}};
        m_wdata_s = {DW{1'b0}};
        if (d_gnt_s) begin
            m_we_s    = bus.d_we;
            m_mask_s  = bus.d_mask;
            m_addr_s  = bus.d_addr;
            m_wdata_s = bus.d_wdata;
        end else if (i_gnt_s) begin
            m_addr_s  = bus.i_addr;
        end else begin
            m_we_s    = 1'b0;
            m_mask_s  = {MW{1'b0}};
            m_addr_s  = {AW{1'b0}};
            m_wdata_s = {DW{1'b0}};
        end
    end

    // Owner state register: response ownership for the next cycle, plus the early-flush marker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r  <= OWN_NONE;
            i_drop_r <= 1'b0;
        end else begin
            owner_r  <= owner_nxt_s;
            i_drop_r <= i_drop_nxt_s;
        end
    end

    // Owner next state: loaded from this cycle's grant; a flush during a fetch grant marks it dropped.
    always_comb begin
        owner_nxt_s  = OWN_NONE;
        i_drop_nxt_s = 1'b0;
        if (i_gnt_s) begin
            owner_nxt_s  = OWN_I;
            i_drop_nxt_s = bus.i_flush;
        end else if (d_gnt_s && bus.d_we) begin
            owner_nxt_s  = OWN_DW;
        end else if (d_gnt_s) begin
            owner_nxt_s  = OWN_DR;
        end else begin
            owner_nxt_s  = OWN_NONE;
        end
    end

    // Response routing: the owner selects which port sees the memory read data this cycle.
    always_comb begin
        i_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
        i_rdata_s  = i_hold_r;
        d_rdata_s  = d_hold_r;
        case (owner_r)
            OWN_I: begin
                if (!i_drop_r && !bus.i_flush) begin
                    i_rvalid_s = 1'b1;
                    i_rdata_s  = bus.m_rdata;
                end else begin
                    i_rvalid_s = 1'b0;
                    i_rdata_s  = i_hold_r;
                end
            end
            OWN_DR: begin
                d_rvalid_s = 1'b1;
                d_rdata_s  = bus.m_rdata;
            end
            OWN_DW: begin
                d_rvalid_s = 1'b1;
                d_rdata_s  = {DW{1'b0}};
            end
            default: begin
                i_rvalid_s = 1'b0;
                d_rvalid_s = 1'b0;
            end
        endcase
    end

    // Fetch hold register: keeps the last delivered fetch word between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_hold_r <= {DW{1'b0}};
        end else if (i_rvalid_s) begin
            i_hold_r <= i_rdata_s;
        end else begin
            i_hold_r <= i_hold_r;
        end
    end

    // Data hold register: keeps the last delivered load result (zero after a write ack).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_hold_r <= {DW{1'b0}};
        end else if (d_rvalid_s) begin
            d_hold_r <= d_rdata_s;
        end else begin
            d_hold_r <= d_hold_r;
        end
    end

    // Drive the bundle outputs.
    always_comb begin
        bus.i_gnt    = i_gnt_s;
        bus.d_gnt    = d_gnt_s;
        bus.m_req    = i_gnt_s | d_gnt_s;
        bus.m_we     = m_we_s;
        bus.m_mask   = m_mask_s;
        bus.m_addr   = m_addr_s;
        bus.m_wdata  = m_wdata_s;
        bus.i_rvalid = i_rvalid_s;
        bus.i_rdata  = i_rdata_s;
        bus.d_rvalid = d_rvalid_s;
        bus.d_rdata  = d_rdata_s;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (starvation pattern, reset during a response) and randomized
// traffic checked against a transaction-level reference model.
// Honours MEM_PORT_ARBITER_STARVE_GUARD_EN for the expected grant pattern.

module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int STARVE_LIMIT = 4;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] init_val(int i);
        logic [DW-1:0] v;
        v = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
        if (i == 5)  v = 32'hDEADBEEF;
        if (i == 16) v = 32'hAAAAAAAA;
        return v;
    endfunction

    // Memory model: registered read, byte-masked write
    logic [DW-1:0] mem [0:1023];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.m_req) begin
            if (bus.m_we) begin
                for (int b = 0; b < MW; b++)
                    if (bus.m_mask[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end else begin
                bus.m_rdata <= mem[bus.m_addr];
            end
        end
    end

    // Reference model state (transaction level)
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] ref_mem [0:1023];
    int            wait_cnt;
    bit            pend_v;
    int            pend_port;    // 0 fetch, 1 data read, 2 data write
    logic [DW-1:0] pend_data;
    bit            pend_drop;
    logic [DW-1:0] i_hold_m, d_hold_m;
    bit            e_ig, e_dg, e_iv, e_dv;
    logic [DW-1:0] e_drd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit ir, int ia, bit fl, bit dr, bit dwe, logic [3:0] dm, int da, logic [31:0] dwd);
        bus.i_req   = ir;
        bus.i_addr  = AW'(ia);
        bus.i_flush = fl;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_mask  = dm;
        bus.d_addr  = AW'(da);
        bus.d_wdata = dwd;
    endtask

    task automatic model_reset();
        wait_cnt = 0;
        pend_v   = 1'b0;
        pend_drop = 1'b0;
        i_hold_m = '0;
        d_hold_m = '0;
    endtask

    // Compare DUT outputs with the model at the falling edge
    task automatic model_check();
        logic [DW-1:0] e_ird;
        @(negedge clk);
        e_ig = bus.i_req && (!bus.d_req || (GUARD && wait_cnt >= STARVE_LIMIT));
        e_dg = bus.d_req && !e_ig;
        chk("i_gnt", bus.i_gnt, e_ig);
        chk("d_gnt", bus.d_gnt, e_dg);
        chk("m_req", bus.m_req, e_ig | e_dg);
        if (e_dg) begin
            chk("m_we_d",    bus.m_we,    bus.d_we);
            chk("m_mask_d",  bus.m_mask,  bus.d_mask);
            chk("m_addr_d",  bus.m_addr,  bus.d_addr);
            chk("m_wdata_d", bus.m_wdata, bus.d_wdata);
        end else if (e_ig) begin
            chk("m_we_i",   bus.m_we,   0);
            chk("m_mask_i", bus.m_mask, 0);
            chk("m_addr_i", bus.m_addr, bus.i_addr);
        end else begin
            chk("m_idle", {bus.m_we, bus.m_mask, bus.m_addr, bus.m_wdata[16:0]}, 0);
        end
        e_iv  = pend_v && pend_port == 0 && !pend_drop && !bus.i_flush;
        e_dv  = pend_v && pend_port != 0;
        e_ird = e_iv ? pend_data : i_hold_m;
        e_drd = e_dv ? (pend_port == 1 ? pend_data : 32'h0) : d_hold_m;
        chk("i_rvalid", bus.i_rvalid, e_iv);
        chk("d_rvalid", bus.d_rvalid, e_dv);
        chk("i_rdata",  bus.i_rdata,  e_ird);
        chk("d_rdata",  bus.d_rdata,  e_drd);
        chk("one_rvalid", bus.i_rvalid & bus.d_rvalid, 0);
    endtask

    // Advance the model across the rising edge
    task automatic model_update();
        @(posedge clk);
        if (e_iv) i_hold_m = pend_data;
        if (e_dv) d_hold_m = e_drd;
        pend_v = e_ig | e_dg;
        pend_drop = 1'b0;
        if (e_ig) begin
            pend_port = 0;
            pend_data = ref_mem[bus.i_addr];
            pend_drop = bus.i_flush;
        end else if (e_dg && bus.d_we) begin
            pend_port = 2;
            for (int b = 0; b < MW; b++)
                if (bus.d_mask[b]) ref_mem[bus.d_addr][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end else if (e_dg) begin
            pend_port = 1;
            pend_data = ref_mem[bus.d_addr];
        end
        if (!bus.i_req || e_ig) wait_cnt = 0;
        else if (e_dg) wait_cnt++;
        #1;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_gnt"},    {bus.i_gnt, bus.d_gnt}, 0);
        chk({tag, "_rvalid"}, {bus.i_rvalid, bus.d_rvalid}, 0);
        chk({tag, "_i_rdata"}, bus.i_rdata, 0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 0);
        chk({tag, "_m_ctl"},  {bus.m_req, bus.m_we, bus.m_mask, bus.m_addr}, 0);
        chk({tag, "_m_wdata"}, bus.m_wdata, 0);
    endtask

    typedef struct {
        bit ir; int ia; bit fl;
        bit dr; bit dwe; logic [3:0] dm; int da; logic [31:0] dwd;
        bit x_ig; bit x_dg; bit x_iv; logic [31:0] x_ird; bit x_dv; logic [31:0] x_drd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [9:0] pat;
        bit ir, dr;

        //        ir  ia     fl  dr  we  mask     da     wdata          ig  dg  iv  i_rdata        dv  d_rdata
        tbl[0]  = '{1'b1, 5,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 0,  1'b0, 1'b1, 1'b1, 4'b0101, 16, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 4'b0000, 16, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hAA22AA44};
        tbl[5]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hAA22AA44};
        tbl[6]  = '{1'b1, 16, 1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hAA22AA44};
        tbl[7]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hAA22AA44};
        tbl[8]  = '{1'b1, 16, 1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hAA22AA44};
        tbl[9]  = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 4'b0000, 5,  32'h0,        1'b0, 1'b1, 1'b1, 32'hAA22AA44, 1'b0, 32'hAA22AA44};
        tbl[10] = '{1'b1, 5,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b1, 1'b0, 1'b0, 32'hAA22AA44, 1'b1, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 4'b0000, 16, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        tbl[12] = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 4'b0000, 0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hAA22AA44};

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        model_reset();
        e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_drd = '0;

        // Reset state: requests held high must not be granted
        rst = 1'b0;
        drive(1'b1, 3, 1'b0, 1'b1, 1'b1, 4'hF, 7, 32'h12345678);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        rst = 1'b1;

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            drive(tbl[v].ir, tbl[v].ia, tbl[v].fl, tbl[v].dr, tbl[v].dwe, tbl[v].dm, tbl[v].da, tbl[v].dwd);
            model_check();
            chk($sformatf("tbl%0d_i_gnt", v),    bus.i_gnt,    tbl[v].x_ig);
            chk($sformatf("tbl%0d_d_gnt", v),    bus.d_gnt,    tbl[v].x_dg);
            chk($sformatf("tbl%0d_i_rvalid", v), bus.i_rvalid, tbl[v].x_iv);
            chk($sformatf("tbl%0d_i_rdata", v),  bus.i_rdata,  tbl[v].x_ird);
            chk($sformatf("tbl%0d_d_rvalid", v), bus.d_rvalid, tbl[v].x_dv);
            chk($sformatf("tbl%0d_d_rdata", v),  bus.d_rdata,  tbl[v].x_drd);
            model_update();
        end

        // Starvation: both requesters held for 10 cycles after an idle cycle
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        model_check();
        model_update();
        pat = GUARD ? 10'b0000100001 : 10'b0000000000;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 5, 1'b0, 1'b1, 1'b0, 4'h0, 16 + k, 32'h0);
            model_check();
            chk($sformatf("starve%0d_i_gnt", k), bus.i_gnt, pat[9-k]);
            chk($sformatf("starve%0d_d_gnt", k), bus.d_gnt, !pat[9-k]);
            model_update();
        end

        // Reset in the response cycle of a data read
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 4'h0, 16, 32'h0);
        model_check();
        model_update();
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        rst = 1'b1;
        model_check();
        chk("post_rst_i_gnt", bus.i_gnt, 1);
        model_update();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        model_check();
        chk("post_rst_i_rvalid", bus.i_rvalid, 1);
        chk("post_rst_i_rdata",  bus.i_rdata,  32'hDEADBEEF);
        model_update();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            ir = ($urandom % 4) != 0;
            dr = ($urandom % 4) != 0;
            drive(ir, $urandom_range(0, 31), ($urandom % 8) == 0, dr, $urandom % 2,
                  4'($urandom), $urandom_range(0, 31), $urandom);
            model_check();
            model_update();
        end

        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
